// File: rtl/barrel_pkg.sv
// Shared helpers for the barrel shifter: ceil-log2 and a legality check
// on the shift-port width against the largest honoured shift.
package barrel_pkg;

   // Ceil(log2(v)); clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // The shift port must be able to encode SHIFT_MAX, and SHIFT_MAX must be
   // a real right shift that still leaves at least one input bit in view.
   function automatic bit params_ok(input int width, input int shift_width,
                                    input int shift_max);
      return (width >= 2) && (shift_max >= 0) && (shift_max <= width - 1) &&
             (shift_width >= 1) && (shift_width >= clog2(shift_max + 1));
   endfunction

endpackage

// File: rtl/barrel_stage.sv
// One level of the log-depth shift network: moves the 2*WIDTH funnel word
// right by a fixed power-of-two AMOUNT when sel is set.
module barrel_stage #(
   parameter int WIDTH  = 32,
   parameter int AMOUNT = 1
) (
   input  logic                 sel,
   input  logic [2*WIDTH-1:0]   din,
   output logic [2*WIDTH-1:0]   dout
);

   // Vacated top bits fill with zero; the total shift never exceeds
   // WIDTH-1, so they never reach the low half that forms the result.
   always_comb begin
      dout = din;
      if (sel) dout = din >> AMOUNT;
   end

endmodule

// File: rtl/barrel.sv
// Right barrel shifter: funnel shift of {ex,in} or arithmetic shift of in,
// by a clamped run-time amount. Optional input register, registered output.
module barrel
   import barrel_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SHIFT_WIDTH = 5,
   parameter int SHIFT_MAX   = 30,
   parameter int IS_REG_IN   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   is_signed,
   input  logic [SHIFT_WIDTH-1:0] shift,
   input  logic [WIDTH-1:0]       in,
   input  logic [WIDTH-1:0]       ex,
   output logic [WIDTH-1:0]       out
);

   localparam logic [SHIFT_WIDTH-1:0] SMAX = SHIFT_WIDTH'(SHIFT_MAX);

   if (!params_ok(WIDTH, SHIFT_WIDTH, SHIFT_MAX)) begin : g_param_err
      $error("barrel: illegal WIDTH/SHIFT_WIDTH/SHIFT_MAX combination");
   end

   // Operands as seen by the network; all four always come from one sample.
   logic [WIDTH-1:0]       in_q;
   logic [WIDTH-1:0]       ex_q;
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic                   signed_q;

   if (IS_REG_IN != 0) begin : g_reg_in
      // Input stage: capture every operand together so a result never mixes
      // fields from different cycles.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            in_q     <= '0;
            ex_q     <= '0;
            shift_q  <= '0;
            signed_q <= 1'b0;
         end else if (enable) begin
            in_q     <= in;
            ex_q     <= ex;
            shift_q  <= shift;
            signed_q <= is_signed;
         end
      end
   end else begin : g_no_reg_in
      assign in_q     = in;
      assign ex_q     = ex;
      assign shift_q  = shift;
      assign signed_q = is_signed;
   end

   // Clamp and funnel construction.
   logic [SHIFT_WIDTH-1:0]                  s;
   logic [WIDTH-1:0]                        fill_hi;
   logic [SHIFT_WIDTH:0][2*WIDTH-1:0]       fun;

   // Requests past SHIFT_MAX saturate; the signed path replaces ex with the
   // sign so an undriven ex cannot leak into the result.
   always_comb begin
      s       = (shift_q > SMAX) ? SMAX : shift_q;
      fill_hi = signed_q ? {WIDTH{in_q[WIDTH-1]}} : ex_q;
   end

   assign fun[0] = {fill_hi, in_q};

   for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
      barrel_stage #(
         .WIDTH  (WIDTH),
         .AMOUNT (1 << k)
      ) u_stage (
         .sel  (s[k]),
         .din  (fun[k]),
         .dout (fun[k+1])
      );
   end

   // Upper funnel half after the last stage is scratch only.
   logic [WIDTH-1:0] unused_hi;
   assign unused_hi = fun[SHIFT_WIDTH][2*WIDTH-1:WIDTH];

   // Output register: low half of the shifted funnel, held while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      out <= '0;
      else if (enable) out <= fun[SHIFT_WIDTH][WIDTH-1:0];
   end

endmodule

// File: tb/tb_barrel.sv
// Bench for barrel: two instances (with and without input register) share
// stimulus; each is compared against a history of model results.
module tb_barrel;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        sg;
   logic [4:0]  sh;
   logic [31:0] di;
   logic [31:0] de;
   logic [31:0] out0;
   logic [31:0] out1;

   int checks = 0;
   int errors = 0;

   // hist holds model results of each enabled sample, newest last.
   logic [31:0] hist[$];

   barrel #(.WIDTH(32), .SHIFT_WIDTH(5), .SHIFT_MAX(30), .IS_REG_IN(0)) u_r0 (
      .clk(clk), .rst_n(rst_n), .enable(en), .is_signed(sg),
      .shift(sh), .in(di), .ex(de), .out(out0));

   barrel #(.WIDTH(32), .SHIFT_WIDTH(5), .SHIFT_MAX(30), .IS_REG_IN(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .enable(en), .is_signed(sg),
      .shift(sh), .in(di), .ex(de), .out(out1));

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] i, input logic [31:0] e,
                                         input logic [4:0] shv, input logic sgn);
      int          n;
      logic [63:0] f;
      n = (shv > 5'd30) ? 30 : int'(shv);
      f = {e, i};
      if (sgn) return 32'($signed(i) >>> n);
      return 32'(f >> n);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n && en) begin
         hist.push_back(model(di, de, sh, sg));
         if (hist.size() > 4) void'(hist.pop_front());
      end
      @(negedge clk);
      chk("lat1", out0, hist[hist.size()-1]);
      chk("lat2", out1, hist[hist.size()-2]);
   endtask

   task automatic drive(input logic s_, input logic [4:0] sh_,
                        input logic [31:0] i_, input logic [31:0] e_);
      sg = s_; sh = sh_; di = i_; de = e_;
   endtask

   task automatic rand_in();
      drive(1'($urandom), 5'($urandom), $urandom, $urandom);
   endtask

   initial begin
      logic [31:0] h0, h1;
      clk = 1'b0; rst_n = 1'b0; en = 1'b1;
      rand_in();
      hist = '{32'h0, 32'h0};
      #3;
      chk("rst_r0", out0, 32'h0);
      chk("rst_r1", out1, 32'h0);
      repeat (2) begin rand_in(); step(); end
      rst_n = 1'b1;

      // Funnel fill from ex.
      drive(1'b0, 5'd8, 32'h0000_0000, 32'hCAFE_DECA);
      step(); step();
      chk("funnel", out1, 32'hCA00_0000);

      // Sign fill keeps all-ones.
      drive(1'b1, 5'd5, 32'hFFFF_FFFF, $urandom);
      step(); step();
      chk("ones", out1, 32'hFFFF_FFFF);

      drive(1'b1, 5'd4, 32'h8000_0000, $urandom);
      step(); step();
      chk("sign4", out1, 32'hF800_0000);

      // Clamp: 31 behaves as 30.
      drive(1'b0, 5'd31, 32'h8000_0000, 32'h0);
      step(); step();
      chk("clamp31", out1, 32'h0000_0002);
      drive(1'b0, 5'd30, 32'h8000_0000, 32'h0);
      step(); step();
      chk("clamp30", out1, 32'h0000_0002);
      drive(1'b0, 5'd0, 32'h1234_5678, 32'hFFFF_FFFF);
      step(); step();
      chk("zero_sh", out1, 32'h1234_5678);

      // Undriven ex must not matter on the signed path.
      drive(1'b1, 5'd7, 32'h9ABC_DEF0, 32'hx);
      step();
      drive(1'b1, 5'd31, 32'h4000_0001, 32'hx);
      step(); step();
      chk("xsig", out1, 32'h0000_0001);

      // Freeze with enable low while inputs move.
      h0 = hist[hist.size()-1];
      h1 = hist[hist.size()-2];
      en = 1'b0;
      repeat (3) begin
         rand_in(); step();
         chk("hold0", out0, h0);
         chk("hold1", out1, h1);
      end
      en = 1'b1;
      repeat (4) begin rand_in(); step(); end

      // Sweep: decrementing in, incrementing shift, alternating mode.
      drive(1'b0, 5'd0, 32'h0, 32'hCAFE_DECA);
      for (int c = 0; c < 1000; c++) begin
         step();
         di = di - 32'd1;
         sh = sh + 5'd1;
         sg = ~sg;
      end

      // Random operands with random enable gaps.
      for (int c = 0; c < 300; c++) begin
         rand_in();
         en = ($urandom_range(3) != 0);
         step();
      end
      en = 1'b1;

      // Asynchronous reset mid-cycle, then flush and restart.
      rand_in(); step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_r0", out0, 32'h0);
      chk("arst_r1", out1, 32'h0);
      hist = '{32'h0, 32'h0};
      rand_in(); step();
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin rand_in(); step(); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
